// File: rtl/regfile_mp_scoreboard.sv
// rtl/regfile_mp_scoreboard.sv - multi-read, dual-write register file with pending scoreboard (optional write-first forwarding under REGFILE_BYPASS_EN)
module regfile_mp_scoreboard #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int AW   = 5,
  parameter int NRD  = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NRD*AW-1:0]   ra,
  output logic [NRD*XLEN-1:0] rd,
  output logic [NRD-1:0]      rd_busy,
  input  logic                we0,
  input  logic [AW-1:0]       wa0,
  input  logic [XLEN-1:0]     wd0,
  input  logic                we1,
  input  logic [AW-1:0]       wa1,
  input  logic [XLEN-1:0]     wd1,
  input  logic                iss_en,
  input  logic [AW-1:0]       iss_rd,
  input  logic                flush,
  output logic [AW:0]         pend_cnt
);

  logic [XLEN-1:0] regs [NREG];
  logic [NREG-1:0] pend;
  logic [NREG-1:0] pend_nxt;

  function automatic logic [AW:0] popcount(input logic [NREG-1:0] p);
    logic [AW:0] c;
    c = '0;
    for (int k = 0; k < NREG; k++) begin
      c = c + (AW+1)'(p[k]);
    end
    return c;
  endfunction

  // Register writes; port 0 is applied last so it wins a same-address conflict
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < NREG; r++) begin
        regs[r] <= '0;
      end
    end else begin
      if (we1 && (wa1 != '0)) regs[wa1] <= wd1;
      if (we0 && (wa0 != '0)) regs[wa0] <= wd0;
    end
  end

  // Next pending set: flush, then writeback clears, then issue sets (issue supersedes completion)
  always_comb begin
    pend_nxt = flush ? '0 : pend;
    if (we0) pend_nxt[wa0] = 1'b0;
    if (we1) pend_nxt[wa1] = 1'b0;
    if (iss_en) pend_nxt[iss_rd] = 1'b1;
    pend_nxt[0] = 1'b0;
  end

  // Scoreboard flags and their registered population count
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend     <= '0;
      pend_cnt <= '0;
    end else begin
      pend     <= pend_nxt;
      pend_cnt <= popcount(pend_nxt);
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NRD; gi++) begin : gen_rd
      logic [AW-1:0] a;
      assign a = ra[gi*AW +: AW];
`ifdef REGFILE_BYPASS_EN
      // Read port with write-first forwarding from port 0, then port 1
      always_comb begin
        rd[gi*XLEN +: XLEN] = regs[a];
        rd_busy[gi]         = pend[a];
        if (we0 && (wa0 == a) && (a != '0)) begin
          rd[gi*XLEN +: XLEN] = wd0;
          rd_busy[gi]         = iss_en && (iss_rd == a);
        end else if (we1 && (wa1 == a) && (a != '0)) begin
          rd[gi*XLEN +: XLEN] = wd1;
          rd_busy[gi]         = iss_en && (iss_rd == a);
        end
      end
`else
      // Read port returning stored state only; x0 and pend[0] are never written
      always_comb begin
        rd[gi*XLEN +: XLEN] = regs[a];
        rd_busy[gi]         = pend[a];
      end
`endif
    end
  endgenerate

endmodule

// File: tb/tb_regfile_mp_scoreboard.sv
// tb/tb_regfile_mp_scoreboard.sv - directed self-checking bench for regfile_mp_scoreboard
module tb_regfile_mp_scoreboard;

  localparam int XLEN = 32;
  localparam int AW   = 5;
  localparam int NRD  = 2;

  logic                clk;
  logic                rst;
  logic [NRD*AW-1:0]   ra;
  logic [NRD*XLEN-1:0] rd;
  logic [NRD-1:0]      rd_busy;
  logic                we0, we1, iss_en, flush;
  logic [AW-1:0]       wa0, wa1, iss_rd;
  logic [XLEN-1:0]     wd0, wd1;
  logic [AW:0]         pend_cnt;

  int tests;
  int fails;

  regfile_mp_scoreboard #(.XLEN(XLEN), .NREG(32), .AW(AW), .NRD(NRD)) dut (
    .clk(clk), .rst(rst), .ra(ra), .rd(rd), .rd_busy(rd_busy),
    .we0(we0), .wa0(wa0), .wd0(wd0), .we1(we1), .wa1(wa1), .wd1(wd1),
    .iss_en(iss_en), .iss_rd(iss_rd), .flush(flush), .pend_cnt(pend_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    we0 = 0; we1 = 0; iss_en = 0; flush = 0;
    wa0 = '0; wa1 = '0; iss_rd = '0; wd0 = '0; wd1 = '0;
  endtask

  task automatic test_reset();
    rst = 0;
    idle();
    ra = {5'd2, 5'd1};
    #3;
    tests++; if (rd !== 64'h0) begin fails++; $display("FAIL reset_rd actual=%h expected=0", rd); end
    tests++; if (rd_busy !== 2'b00) begin fails++; $display("FAIL reset_busy actual=%b expected=00", rd_busy); end
    tests++; if (pend_cnt !== 6'd0) begin fails++; $display("FAIL reset_cnt actual=%0d expected=0", pend_cnt); end
    @(negedge clk);
    rst = 1;
    we0 = 1; wa0 = 5'd1; wd0 = 32'hA5A5A5A5;
    tick();
    idle();
    #1;
    tests++; if (rd[31:0] !== 32'hA5A5A5A5) begin fails++; $display("FAIL reset_first_write actual=%h expected=a5a5a5a5", rd[31:0]); end
  endtask

  task automatic test_x0();
    we0 = 1; wa0 = 5'd0; wd0 = 32'hFFFFFFFF;
    iss_en = 1; iss_rd = 5'd0;
    tick();
    idle();
    ra = {5'd1, 5'd0};
    #1;
    tests++; if (rd[31:0] !== 32'h0) begin fails++; $display("FAIL x0_data actual=%h expected=0", rd[31:0]); end
    tests++; if (rd_busy[0] !== 1'b0) begin fails++; $display("FAIL x0_busy actual=%b expected=0", rd_busy[0]); end
    tests++; if (pend_cnt !== 6'd0) begin fails++; $display("FAIL x0_cnt actual=%0d expected=0", pend_cnt); end
  endtask

  task automatic test_dual_write();
    we0 = 1; wa0 = 5'd2; wd0 = 32'h12345678;
    we1 = 1; wa1 = 5'd2; wd1 = 32'hDEADBEEF;
    tick();
    idle();
    ra = {5'd0, 5'd2};
    #1;
    tests++; if (rd[31:0] !== 32'h12345678) begin fails++; $display("FAIL dual_conflict actual=%h expected=12345678", rd[31:0]); end
    we0 = 1; wa0 = 5'd3; wd0 = 32'd1;
    we1 = 1; wa1 = 5'd4; wd1 = 32'd2;
    tick();
    idle();
    ra = {5'd4, 5'd3};
    #1;
    tests++; if (rd[31:0] !== 32'd1) begin fails++; $display("FAIL dual_sep_x3 actual=%h expected=1", rd[31:0]); end
    tests++; if (rd[63:32] !== 32'd2) begin fails++; $display("FAIL dual_sep_x4 actual=%h expected=2", rd[63:32]); end
  endtask

  task automatic test_scoreboard();
    iss_en = 1; iss_rd = 5'd5;
    tick();
    idle();
    ra = {5'd0, 5'd5};
    #1;
    tests++; if (rd_busy[0] !== 1'b1) begin fails++; $display("FAIL sb_issue_busy actual=%b expected=1", rd_busy[0]); end
    tests++; if (pend_cnt !== 6'd1) begin fails++; $display("FAIL sb_issue_cnt actual=%0d expected=1", pend_cnt); end
    we1 = 1; wa1 = 5'd5; wd1 = 32'hCAFEF00D;
    tick();
    idle();
    #1;
    tests++; if (rd_busy[0] !== 1'b0) begin fails++; $display("FAIL sb_wb_busy actual=%b expected=0", rd_busy[0]); end
    tests++; if (pend_cnt !== 6'd0) begin fails++; $display("FAIL sb_wb_cnt actual=%0d expected=0", pend_cnt); end
    tests++; if (rd[31:0] !== 32'hCAFEF00D) begin fails++; $display("FAIL sb_wb_data actual=%h expected=cafef00d", rd[31:0]); end
    iss_en = 1; iss_rd = 5'd5;
    we0 = 1; wa0 = 5'd5; wd0 = 32'h11111111;
    tick();
    idle();
    #1;
    tests++; if (rd_busy[0] !== 1'b1) begin fails++; $display("FAIL sb_setclr_busy actual=%b expected=1", rd_busy[0]); end
    tests++; if (pend_cnt !== 6'd1) begin fails++; $display("FAIL sb_setclr_cnt actual=%0d expected=1", pend_cnt); end
    tests++; if (rd[31:0] !== 32'h11111111) begin fails++; $display("FAIL sb_setclr_data actual=%h expected=11111111", rd[31:0]); end
    // retire x5, pend x11 and x12
    we0 = 1; wa0 = 5'd5; wd0 = 32'h11111111;
    iss_en = 1; iss_rd = 5'd11;
    tick();
    idle();
    iss_en = 1; iss_rd = 5'd12;
    tick();
    idle();
    #1;
    tests++; if (pend_cnt !== 6'd2) begin fails++; $display("FAIL sb_two_cnt actual=%0d expected=2", pend_cnt); end
    // +1 -2 in one cycle
    iss_en = 1; iss_rd = 5'd13;
    we0 = 1; wa0 = 5'd11; wd0 = 32'h0B;
    we1 = 1; wa1 = 5'd12; wd1 = 32'h0C;
    tick();
    idle();
    ra = {5'd11, 5'd13};
    #1;
    tests++; if (pend_cnt !== 6'd1) begin fails++; $display("FAIL sb_net_cnt actual=%0d expected=1", pend_cnt); end
    tests++; if (rd_busy !== 2'b01) begin fails++; $display("FAIL sb_net_busy actual=%b expected=01", rd_busy); end
    // write to a non-pending register leaves its flag clear
    we0 = 1; wa0 = 5'd13; wd0 = 32'h0D;
    we1 = 1; wa1 = 5'd11; wd1 = 32'hBB;
    tick();
    idle();
    #1;
    tests++; if (pend_cnt !== 6'd0) begin fails++; $display("FAIL sb_nonpend_cnt actual=%0d expected=0", pend_cnt); end
    tests++; if (rd_busy !== 2'b00) begin fails++; $display("FAIL sb_nonpend_busy actual=%b expected=00", rd_busy); end
  endtask

  task automatic test_flush();
    for (int r = 6; r <= 8; r++) begin
      iss_en = 1; iss_rd = AW'(r);
      tick();
    end
    idle();
    #1;
    tests++; if (pend_cnt !== 6'd3) begin fails++; $display("FAIL flush_pre_cnt actual=%0d expected=3", pend_cnt); end
    flush = 1; iss_en = 1; iss_rd = 5'd9;
    tick();
    idle();
    ra = {5'd6, 5'd9};
    #1;
    tests++; if (pend_cnt !== 6'd1) begin fails++; $display("FAIL flush_cnt actual=%0d expected=1", pend_cnt); end
    tests++; if (rd_busy !== 2'b01) begin fails++; $display("FAIL flush_busy actual=%b expected=01", rd_busy); end
    we0 = 1; wa0 = 5'd9; wd0 = 32'h9;
    tick();
    idle();
    #1;
    tests++; if (pend_cnt !== 6'd0) begin fails++; $display("FAIL flush_retire_cnt actual=%0d expected=0", pend_cnt); end
  endtask

  task automatic test_bypass();
    logic [31:0] exp_same;
    logic        exp_busy;
`ifdef REGFILE_BYPASS_EN
    exp_same = 32'h0BADC0DE;
    exp_busy = 1'b0;
`else
    exp_same = 32'h0;
    exp_busy = 1'b1;
`endif
    iss_en = 1; iss_rd = 5'd10;
    tick();
    idle();
    ra = {5'd0, 5'd10};
    we0 = 1; wa0 = 5'd10; wd0 = 32'h0BADC0DE;
    #1;
    tests++; if (rd[31:0] !== exp_same) begin fails++; $display("FAIL bypass_same_data actual=%h expected=%h", rd[31:0], exp_same); end
    tests++; if (rd_busy[0] !== exp_busy) begin fails++; $display("FAIL bypass_same_busy actual=%b expected=%b", rd_busy[0], exp_busy); end
    tick();
    idle();
    #1;
    tests++; if (rd[31:0] !== 32'h0BADC0DE) begin fails++; $display("FAIL bypass_next_data actual=%h expected=0badc0de", rd[31:0]); end
    tests++; if (rd_busy[0] !== 1'b0) begin fails++; $display("FAIL bypass_next_busy actual=%b expected=0", rd_busy[0]); end
  endtask

  task automatic test_async_reset();
    iss_en = 1; iss_rd = 5'd14;
    tick();
    idle();
    ra = {5'd14, 5'd1};
    #2;
    rst = 0;
    #1;
    tests++; if (pend_cnt !== 6'd0) begin fails++; $display("FAIL areset_cnt actual=%0d expected=0", pend_cnt); end
    tests++; if (rd !== 64'h0) begin fails++; $display("FAIL areset_rd actual=%h expected=0", rd); end
    tests++; if (rd_busy !== 2'b00) begin fails++; $display("FAIL areset_busy actual=%b expected=00", rd_busy); end
    @(negedge clk);
    rst = 1;
  endtask

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_x0();
    test_dual_write();
    test_scoreboard();
    test_flush();
    test_bypass();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/regfile_mp_scoreboard.md
Name: regfile_mp_scoreboard

Overview:
Parametrised successor to the core's 2-read/1-write register file. It has NRD read ports and two write ports: port 0 for pipeline writeback, port 1 for late or long-latency results. A per-register pending scoreboard is set at issue and cleared at writeback, and a pending-count output drives hazard and stall logic. x0 is hardwired to zero.

Parameters:
XLEN, 32, data width of each register
NREG, 32, number of architectural registers (power of 2, >=2)
AW, 5, address width, must equal log2(NREG)
NRD, 2, number of read ports (1..4)

Ports:
clk  in  1  clock, rising-edge active
rst  in  1  reset, asynchronous, active-low
ra  in  NRD*AW  packed read addresses; port i at bits [i*AW +: AW]
rd  out  NRD*XLEN  packed read data; port i at bits [i*XLEN +: XLEN]
rd_busy  out  NRD  pending flag of the register addressed on each read port
we0  in  1  write enable, port 0 (writeback)
wa0  in  AW  write address, port 0
wd0  in  XLEN  write data, port 0
we1  in  1  write enable, port 1 (late result)
wa1  in  AW  write address, port 1
wd1  in  XLEN  write data, port 1
iss_en  in  1  issue strobe: mark iss_rd pending
iss_rd  in  AW  destination register being issued
flush  in  1  clear all pending flags (pipeline flush)
pend_cnt  out  AW+1  number of registers currently pending

Behaviour:
- Reset (rst=0, asynchronous): all registers = 0, all pending flags = 0, pend_cnt = 0. rd is therefore 0 and rd_busy is 0 while reset is held. Reset asserted mid-operation discards all state immediately.
- Reads are combinational. rd[i] = reg[ra[i]]; rd_busy[i] = pend[ra[i]].
- Writes take effect at the rising edge when weN=1 and waN!=0.
- Both write ports targeting the same non-zero address in the same cycle: port 0 data wins, port 1 is dropped.
- x0:
  - Writes to x0 are ignored.
  - Reads of x0 return 0 and rd_busy=0.
  - iss_en with iss_rd=0 is ignored; pend[0] is always 0.
- Pending flag, per register r, evaluated at each edge:
  - Set when iss_en=1 and iss_rd=r.
  - Cleared when (we0 and wa0=r) or (we1 and wa1=r).
  - Set and clear in the same cycle: set wins, because the new producer supersedes the completing one.
  - flush=1 clears all flags; flush together with iss_en: flags cleared, then iss_rd set.
  - A write to a non-pending register is legal; the flag stays 0.
- pend_cnt:
  - Registered; always equals the population count of pend after the edge.
  - Reaches NREG-1 at most, never wraps.
  - Same-cycle set/clear on different registers nets out correctly (e.g. +1-2 = -1).
- Latency: without bypass, write data is visible on rd one cycle after the write edge.

Optional Feature:
Macro REGFILE_BYPASS_EN.
- Defined: write-first forwarding. If we0=1 and wa0=ra[i]!=0, then rd[i]=wd0. Otherwise, if we1=1 and wa1=ra[i]!=0, then rd[i]=wd1. rd_busy[i] is forced to 0 when a forwarding write hits, unless iss_en is re-issuing the same register in that cycle.
- Not defined: rd and rd_busy reflect stored state only; no combinational path from wd/we to rd.

Test Plan:
- Reset: hold rst=0 with ra={1,2} → rd=0, rd_busy=0, pend_cnt=0. Release, write x1=A5A5A5A5 via port 0 → rd[0]=A5A5A5A5 on the next cycle.
- x0 protection: we0=1, wa0=0, wd0=FFFFFFFF and iss_en with iss_rd=0 → reading ra=0 gives 0, rd_busy=0, pend_cnt unchanged.
- Dual-write conflict: we0 writes x2=12345678 and we1 writes x2=DEADBEEF in the same cycle → x2=12345678. Separate addresses (x3=1, x4=2) → both written.
- Scoreboard:
  - Issue x5 → rd_busy=1 for ra=5, pend_cnt=1.
  - Port 1 writes x5=CAFEF00D → busy=0, pend_cnt=0.
  - Issue x5 and write x5 in the same cycle → busy stays 1.
- Flush: issue x6, x7, x8 → pend_cnt=3. Then flush with iss_rd=9 → pend_cnt=1, only x9 busy.
- Bypass (REGFILE_BYPASS_EN): read ra=10 while we0 writes x10=0BADC0DE → rd=0BADC0DE in the same cycle. Without the macro → old value that cycle, new value the next cycle.
